// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multi-cycle control unit for the 16-bit datapath.
// Sequences FETCH -> DECODE -> EXECUTE -> (WRITEBACK) for each instruction,
// fetched over a req/ack port, and drives the datapath control pins.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   start                   pulse in IDLE to begin execution at PC=0
//   instr_req/addr/ack/data instruction fetch handshake (addr = PC)
//   zero_flag, pos_flag     datapath ALU result flags, used by branches
//   rf_write                register file write enable (WRITEBACK only)
//   rs_addr/rt_addr/rd_addr register addresses
//   imm_data, imm_sel       zero-extended imm8 and operand-B select
//   alu_sel                 ALU operation
//   mem_write               register write data comes from mem_data
//   instr_done              one-cycle pulse when an instruction retires
//   halted                  high in HALT state
module datapath_ctrl #(
   parameter int         PC_W     = 8,
   parameter logic [3:0] PASS_SEL = 4'b0000
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   output logic            instr_req,
   output logic [PC_W-1:0] instr_addr,
   input  logic            instr_ack,
   input  logic [15:0]     instr_data,
   input  logic            zero_flag,
   input  logic            pos_flag,
   output logic            rf_write,
   output logic [2:0]      rs_addr,
   output logic [2:0]      rt_addr,
   output logic [2:0]      rd_addr,
   output logic [15:0]     imm_data,
   output logic            imm_sel,
   output logic [3:0]      alu_sel,
   output logic            mem_write,
   output logic            instr_done,
   output logic            halted
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
   } state_t;

   state_t          state, next_state;
   logic [PC_W-1:0] pc;
   logic [15:0]     ir;

   // ---------------- instruction decode (from IR) ----------------
   logic [4:0] op;
   logic       is_r, is_i, is_load, is_bz, is_bp, is_jmp, is_halt;
   logic       writes, branch_taken;
   logic [2:0] dec_rs, dec_rt, dec_rd;
   logic [3:0] dec_alu;
   logic       dec_imm_sel, dec_mem_write;

   assign op      = ir[15:11];
   assign is_r    = ~op[4];
   assign is_i    = (op[4:3] == 2'b10) && !op[0];
   assign is_load = (op == 5'b11000);
   assign is_bz   = (op == 5'b11100);
   assign is_bp   = (op == 5'b11101);
   assign is_jmp  = (op == 5'b11110);
   assign is_halt = (op == 5'b11111);
   assign writes  = is_r | is_i | is_load;

   // Flags are only meaningful in EXECUTE, when alu_sel=PASS_SEL routes rs.
   assign branch_taken = is_jmp | (is_bz & zero_flag) | (is_bp & pos_flag);

   always_comb begin
      dec_rs        = 3'd0;
      dec_rt        = 3'd0;
      dec_rd        = 3'd0;
      dec_alu       = 4'd0;
      dec_imm_sel   = 1'b0;
      dec_mem_write = 1'b0;
      if (is_r) begin
         dec_rs  = ir[7:5];
         dec_rt  = ir[4:2];
         dec_rd  = ir[10:8];
         dec_alu = op[3:0];
      end else if (is_i) begin
         // I-type reads and writes the same register (rd field)
         dec_rs      = ir[10:8];
         dec_rd      = ir[10:8];
         dec_alu     = op[4:1];
         dec_imm_sel = 1'b1;
      end else if (is_load) begin
         dec_rd        = ir[10:8];
         dec_mem_write = 1'b1;
      end else if (is_bz || is_bp) begin
         dec_rs  = ir[10:8];
         dec_alu = PASS_SEL;
      end
   end

   // ---------------- state / PC / IR registers ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
         pc    <= '0;
         ir    <= '0;
      end else begin
         state <= next_state;
         if (state == S_FETCH && instr_ack) begin
            ir <= instr_data;
            pc <= pc + PC_W'(1);
         end
         if (state == S_EXECUTE && branch_taken)
            pc <= PC_W'(ir[7:0]);
      end
   end

   // ---------------- next state and outputs ----------------
   // Operand outputs are a pure function of IR outside IDLE/HALT, so they
   // only change when IR is loaded, i.e. on entry to DECODE, and hold
   // through the following FETCH.
   always_comb begin
      next_state = state;
      instr_req  = 1'b0;
      instr_addr = '0;
      rf_write   = 1'b0;
      rs_addr    = 3'd0;
      rt_addr    = 3'd0;
      rd_addr    = 3'd0;
      imm_data   = 16'd0;
      imm_sel    = 1'b0;
      alu_sel    = 4'd0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
      halted     = 1'b0;

      if (state inside {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK}) begin
         rs_addr   = dec_rs;
         rt_addr   = dec_rt;
         rd_addr   = dec_rd;
         imm_data  = {8'd0, ir[7:0]};
         imm_sel   = dec_imm_sel;
         mem_write = dec_mem_write;
      end
      if (state inside {S_FETCH, S_EXECUTE, S_WRITEBACK})
         alu_sel = dec_alu;

      case (state)
         S_IDLE: begin
            if (start) next_state = S_FETCH;
         end
         S_FETCH: begin
            instr_req  = 1'b1;
            instr_addr = pc;
            if (instr_ack) next_state = S_DECODE;
         end
         S_DECODE: begin
            next_state = S_EXECUTE;
         end
         S_EXECUTE: begin
            if (writes) begin
               next_state = S_WRITEBACK;
            end else begin
               instr_done = 1'b1;
               next_state = is_halt ? S_HALT : S_FETCH;
            end
         end
         S_WRITEBACK: begin
            rf_write   = 1'b1;
            instr_done = 1'b1;
            next_state = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: next_state = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Testbench for datapath_ctrl: table-driven single-instruction vectors plus
// hand-written sequences for fetch stalls, HALT, reset in WRITEBACK and PC wrap.
module tb_datapath_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        instr_req;
   logic [7:0]  instr_addr;
   logic        instr_ack;
   logic [15:0] instr_data;
   logic        zero_flag = 1'b0;
   logic        pos_flag  = 1'b0;
   logic        rf_write;
   logic [2:0]  rs_addr, rt_addr, rd_addr;
   logic [15:0] imm_data;
   logic        imm_sel;
   logic [3:0]  alu_sel;
   logic        mem_write;
   logic        instr_done;
   logic        halted;

   // simple instruction memory responder
   logic [15:0] mem [256];
   logic        ack_en    = 1'b1;
   logic        ack_force = 1'b0;
   assign instr_ack  = (instr_req & ack_en) | ack_force;
   assign instr_data = mem[instr_addr];

   datapath_ctrl #(.PC_W(8), .PASS_SEL(4'b0000)) dut (
      .clock(clock), .reset(reset), .start(start),
      .instr_req(instr_req), .instr_addr(instr_addr),
      .instr_ack(instr_ack), .instr_data(instr_data),
      .zero_flag(zero_flag), .pos_flag(pos_flag),
      .rf_write(rf_write), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rd_addr(rd_addr), .imm_data(imm_data), .imm_sel(imm_sel),
      .alu_sel(alu_sel), .mem_write(mem_write),
      .instr_done(instr_done), .halted(halted)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   function automatic logic [31:0] all_outs();
      return {instr_req, instr_addr, rf_write, rs_addr, rt_addr, rd_addr,
              imm_sel, alu_sel, mem_write, instr_done, halted} | {16'd0, imm_data};
   endfunction

   typedef struct {
      string       name;
      logic [15:0] instr;
      logic        zf, pf;
      logic [2:0]  rs, rt, rd;
      logic [15:0] imm;
      logic        isel;
      logic [3:0]  alu;
      logic        mw;
      logic        wr;
      logic [7:0]  npc;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h8800;

      //          name      instr     zf    pf    rs    rt    rd    imm       isel  alu      mw    wr    npc
      vecs[0] = '{"movi",  16'hB708, 1'b0, 1'b0, 3'd7, 3'd0, 3'd7, 16'h0008, 1'b1, 4'b1011, 1'b0, 1'b1, 8'h01};
      vecs[1] = '{"rtype", 16'h0A94, 1'b0, 1'b0, 3'd4, 3'd5, 3'd2, 16'h0094, 1'b0, 4'b0001, 1'b0, 1'b1, 8'h01};
      vecs[2] = '{"bz_t",  16'hE320, 1'b1, 1'b0, 3'd3, 3'd0, 3'd0, 16'h0020, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h20};
      vecs[3] = '{"bz_nt", 16'hE320, 1'b0, 1'b1, 3'd3, 3'd0, 3'd0, 16'h0020, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h01};
      vecs[4] = '{"bp_t",  16'hEB05, 1'b0, 1'b1, 3'd3, 3'd0, 3'd0, 16'h0005, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h05};
      vecs[5] = '{"jmp",   16'hF010, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0010, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h10};
      vecs[6] = '{"load",  16'hC540, 1'b0, 1'b0, 3'd0, 3'd0, 3'd5, 16'h0040, 1'b0, 4'b0000, 1'b1, 1'b1, 8'h01};
      vecs[7] = '{"nop",   16'h8800, 1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h01};
      vecs[8] = '{"addi",  16'h8203, 1'b0, 1'b0, 3'd2, 3'd0, 3'd2, 16'h0003, 1'b1, 4'b1000, 1'b0, 1'b1, 8'h01};

      // reset state
      do_reset();
      chk("reset_outs", all_outs(), 32'd0);

      // ---------------- table-driven single instructions ----------------
      foreach (vecs[k]) begin
         do_reset();
         mem[0]    = vecs[k].instr;
         zero_flag = vecs[k].zf;
         pos_flag  = vecs[k].pf;
         pulse_start();
         // FETCH (ack same cycle)
         chk({vecs[k].name, "_f_req"}, instr_req, 1'b1);
         chk({vecs[k].name, "_f_addr"}, instr_addr, 8'h00);
         tick();
         // DECODE
         chk({vecs[k].name, "_d_req"}, instr_req, 1'b0);
         chk({vecs[k].name, "_d_ops"}, {rs_addr, rt_addr, rd_addr, imm_data, imm_sel, mem_write},
             {vecs[k].rs, vecs[k].rt, vecs[k].rd, vecs[k].imm, vecs[k].isel, vecs[k].mw});
         chk({vecs[k].name, "_d_wr"}, rf_write, 1'b0);
         tick();
         // EXECUTE
         chk({vecs[k].name, "_e_alu"}, alu_sel, vecs[k].alu);
         chk({vecs[k].name, "_e_ops"}, {rs_addr, rt_addr, rd_addr, imm_data, imm_sel, mem_write},
             {vecs[k].rs, vecs[k].rt, vecs[k].rd, vecs[k].imm, vecs[k].isel, vecs[k].mw});
         chk({vecs[k].name, "_e_wr_done"}, {rf_write, instr_done}, {1'b0, ~vecs[k].wr});
         tick();
         if (vecs[k].wr) begin
            // WRITEBACK
            chk({vecs[k].name, "_w_wr_done"}, {rf_write, instr_done}, 2'b11);
            chk({vecs[k].name, "_w_ops"}, {rs_addr, rt_addr, rd_addr, imm_data, imm_sel, alu_sel, mem_write},
                {vecs[k].rs, vecs[k].rt, vecs[k].rd, vecs[k].imm, vecs[k].isel, vecs[k].alu, vecs[k].mw});
            tick();
         end
         // next FETCH
         chk({vecs[k].name, "_n_req"}, instr_req, 1'b1);
         chk({vecs[k].name, "_n_addr"}, instr_addr, vecs[k].npc);
         chk({vecs[k].name, "_n_wr_done"}, {rf_write, instr_done}, 2'b00);
         mem[0] = 16'h8800;
      end
      zero_flag = 1'b0;
      pos_flag  = 1'b0;

      // ---------------- fetch stall of 5 cycles ----------------
      do_reset();
      mem[0] = 16'hB708;
      ack_en = 1'b0;
      pulse_start();
      for (int c = 0; c < 5; c++) begin
         chk("stall_req_addr", {instr_req, instr_addr}, {1'b1, 8'h00});
         chk("stall_wr", rf_write, 1'b0);
         tick();
      end
      ack_en = 1'b1;
      tick();   // ack cycle -> DECODE
      chk("stall_d_rd", {rd_addr, instr_req}, {3'd7, 1'b0});
      tick();   // EXECUTE
      tick();   // WRITEBACK
      chk("stall_w_wr", rf_write, 1'b1);
      tick();
      chk("stall_next", {instr_req, instr_addr, rf_write}, {1'b1, 8'h01, 1'b0});

      // ---------------- HALT ----------------
      do_reset();
      mem[0] = 16'hFFFF;
      pulse_start();
      tick();   // DECODE
      tick();   // EXECUTE
      tick();   // HALT
      chk("halt_outs", all_outs(), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("halt_stay", {halted, instr_req}, 2'b10);
         tick();
      end
      do_reset();
      chk("halt_reset_outs", all_outs(), 32'd0);
      mem[0] = 16'h8800;

      // ---------------- reset during WRITEBACK, ack in IDLE ----------------
      do_reset();
      mem[0] = 16'hB708;
      pulse_start();
      tick();
      tick();
      tick();   // WRITEBACK
      chk("rwb_pre_wr", rf_write, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rwb_outs", all_outs(), 32'd0);
      ack_force = 1'b1;
      tick();
      tick();
      chk("rwb_idle_ack", all_outs(), 32'd0);
      ack_force = 1'b0;
      pulse_start();
      chk("rwb_restart_pc", {instr_req, instr_addr}, {1'b1, 8'h00});
      mem[0] = 16'h8800;

      // ---------------- PC wrap: JMP 0xFF, NOP at 0xFF -> fetch 0 ----------------
      do_reset();
      mem[0]   = 16'hF0FF;
      mem[255] = 16'h8800;
      pulse_start();
      tick();
      tick();
      tick();   // FETCH at 0xFF
      chk("wrap_jmp_addr", {instr_req, instr_addr}, {1'b1, 8'hFF});
      tick();
      tick();
      chk("wrap_nop_done", instr_done, 1'b1);
      tick();
      chk("wrap_addr0", {instr_req, instr_addr}, {1'b1, 8'h00});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
